// File: rtl/axi_chan_pkg.sv
`default_nettype none
// axi_chan_pkg: types shared by the VALID/READY channel blocks.
// Revision 1.0
package axi_chan_pkg;

   typedef enum logic [1:0] {
      ERR_NONE        = 2'd0,
      ERR_VALID_DROP  = 2'd1,
      ERR_DATA_CHANGE = 2'd2
   } rx_err_t;

endpackage
`default_nettype wire

// File: rtl/rx_channel_if.sv
`default_nettype none
// rx_channel_if: transmitter-side handshake plus sink-side pop interface.
// Revision 1.0
interface rx_channel_if
   import axi_chan_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             VALID;
   logic [WIDTH-1:0] xDATA;
   logic             READY;
   logic             rx_en;
   logic [WIDTH-1:0] rx_data;
   logic             rx_valid;
   logic             rx_rd;
   logic [CW-1:0]    rx_count;
   rx_err_t          rx_err;

   modport slave (
      input  VALID, xDATA, rx_en, rx_rd,
      output READY, rx_data, rx_valid, rx_count, rx_err
   );

   modport master (
      output VALID, xDATA, rx_en, rx_rd,
      input  READY, rx_data, rx_valid, rx_count, rx_err
   );
endinterface
`default_nettype wire

// File: rtl/chan_fifo.sv
`default_nettype none
// chan_fifo: show-ahead FIFO; full/empty are told apart by the count.
// Revision 1.0
module chan_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;
   logic             do_push;
   logic             do_pop;

   always_comb begin
      do_push = push && (cnt != FULL_CNT);
      do_pop  = pop && (cnt != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage carries no reset; the count alone decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push && !rst) mem[wr_ptr] <= push_data;
   end

   always_comb begin
      head  = (cnt != '0) ? mem[rd_ptr] : '0;
      count = cnt;
   end
endmodule
`default_nettype wire

// File: rtl/rx_channel.sv
`default_nettype none
// rx_channel: VALID/READY receiver with FIFO, sink pop port and protocol monitor.
// Revision 1.0
module rx_channel
   import axi_chan_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic          ACLK,
   input  logic          ARESET,
   rx_channel_if.slave   ch
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
      $error("rx_channel: DEPTH must be a power of two and at least 2");
   end

   logic             live;
   logic             ready;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] head;
   logic [CW-1:0]    count;
   logic             prev_pend;
   logic [WIDTH-1:0] prev_data;
   rx_err_t          err;

   // READY is held low through reset and the first cycle after it.
   always_comb begin
      ready = live && !ARESET && ch.rx_en && (count != FULL_CNT);
      push  = ch.VALID && ready;
      pop   = ch.rx_rd && (count != '0);
   end

   chan_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (ACLK),
      .rst       (ARESET),
      .push      (push),
      .push_data (ch.xDATA),
      .pop       (pop),
      .head      (head),
      .count     (count)
   );

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         live      <= 1'b0;
         prev_pend <= 1'b0;
         prev_data <= '0;
         err       <= ERR_NONE;
      end else begin
         live      <= 1'b1;
         prev_pend <= ch.VALID && !ready;
         prev_data <= ch.xDATA;
         // A dropped VALID outranks a data change; only the first error sticks.
         if (err == ERR_NONE && prev_pend) begin
            if (!ch.VALID)                    err <= ERR_VALID_DROP;
            else if (ch.xDATA != prev_data)   err <= ERR_DATA_CHANGE;
         end
      end
   end

   always_comb begin
      ch.READY    = ready;
      ch.rx_data  = head;
      ch.rx_valid = (count != '0);
      ch.rx_count = count;
      ch.rx_err   = err;
   end
endmodule
`default_nettype wire

// File: doc/rx_channel.md
# rx_channel

Receiving end of a single VALID/READY channel. Accepts beats from a channel transmitter into a DEPTH-entry FIFO and drives READY from local enable and free space. Presents buffered beats to the local data sink through a show-ahead pop interface. Monitors the transmitter for handshake-rule violations and latches the first one seen.

## Interface
- WIDTH, 8: beat data width.
- DEPTH, 4: FIFO entries; power of two, ≥2; elaboration error otherwise.
- ACLK  input  1  clock; all logic on rising edge.
- ARESET  input  1  reset, synchronous, active-high.
- VALID  input  1  transmitter has a beat on xDATA.
- xDATA  input  WIDTH  beat data.
- READY  output  1  receiver accepts a beat this cycle.
- rx_en  input  1  receive enable from the sink side.
- rx_data  output  WIDTH  head-of-FIFO beat.
- rx_valid  output  1  rx_data holds a valid beat (FIFO not empty).
- rx_rd  input  1  sink pops the head beat.
- rx_count  output  $clog2(DEPTH)+1  number of beats buffered.
- rx_err  output  2  first protocol error, of type rx_err_t.

## Operation
- Push: beat accepted at an edge where VALID && READY. xDATA is written at wr_ptr, wr_ptr increments, count increments.
- READY = rx_en && (count != DEPTH). Comes from registered count only and never depends on VALID, so there is no combinational loop with the transmitter.
- Pop: at an edge where rx_rd && rx_valid. rd_ptr increments and count decrements. rx_rd while empty is ignored with no pointer movement.
- Simultaneous push and pop with 0 < count < DEPTH: both pointers advance and count is unchanged.
- Full: READY=0, so there is no push and no pass-through even when rx_rd is high. The pop frees a slot and READY rises the next cycle.
- Empty: rx_valid=0 and rx_data=0. A same-cycle push does not bypass to the output.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally. Full and empty are distinguished by count.
- rx_en low: READY=0. Buffered beats remain poppable.
- Protocol monitor:
  - Registers prev_pend = VALID && !READY and prev_data = xDATA every cycle.
  - While rx_err == ERR_NONE and prev_pend is set:
    - If !VALID, the next edge sets ERR_VALID_DROP.
    - Else if xDATA != prev_data, the next edge sets ERR_DATA_CHANGE.
  - VALID drop is checked before data change.
  - rx_err is sticky and cleared only by ARESET. An error does not block data flow.

## Timing
- Reset values while ARESET is high and on the first cycle after:
  - READY=0, rx_valid=0, rx_data=0, rx_count=0, rx_err=ERR_NONE.
  - Pointers = 0, prev_pend = 0.
  - Storage array is not reset.
- Accept-to-visible latency: a beat accepted at edge N gives rx_valid=1 and rx_data equal to that beat from just after edge N.
- Pop effect: after a pop at edge N, rx_data shows the next entry from just after edge N.
- READY recovery: from full, a pop at edge N gives READY=1 after edge N.
- Throughput: one beat per cycle sustained when the sink pops every cycle.
- Reset mid-operation: ARESET at edge N flushes all beats, gives count 0 and READY 0 after N, and discards any beat presented at N.
- rx_en fall at edge N: READY=0 after N. A VALID held by the transmitter across this is pending, not an error. The monitor only checks stability, which the transmitter must keep.

## Structure
- Shared package axi_chan_pkg holds typedef enum logic [1:0] rx_err_t: ERR_NONE=0, ERR_VALID_DROP=1, ERR_DATA_CHANGE=2, value 3 reserved.
- One sub-module, chan_fifo #(WIDTH, DEPTH), contains storage, pointers and count, with a push/pop/count interface.
- rx_channel contains the READY logic and the protocol monitor.

## Test plan
- Reset then single beat: ARESET 2 cycles, then VALID=1, xDATA=8'hA5, rx_en=1 for one edge -> READY=1 after reset cycle, rx_valid=1, rx_data=A5, rx_count=1. After rx_rd, rx_valid=0 and rx_data=0.
- Fill and stall: push 8'h01..8'h04 with no pops, DEPTH=4 -> rx_count=4, READY=0. 8'h05 held on VALID is not accepted. One pop gives rx_data=02, READY=1 next cycle, then 05 is accepted.
- Streaming with wrap: 10 back-to-back beats 8'h10..8'h19 with rx_rd=1 every cycle -> output order 10..19, rx_count ≤1, no stall, pointers wrap twice.
- Simultaneous events: count=2, push 8'h33 and pop in the same edge -> count stays 2 and the head advances. rx_rd on empty -> no change.
- Protocol errors:
  - With READY=0 (rx_en=0), VALID=1 and xDATA=8'h11, then VALID=0 -> rx_err=ERR_VALID_DROP.
  - After reset, the same setup with xDATA changed to 8'h12 -> ERR_DATA_CHANGE.
  - A later violation does not overwrite the latched error.
- Reset mid-stream: count=3, ARESET for one edge -> count 0, rx_valid 0, READY 0, rx_err cleared. The next push of 8'h77 is the head.
